// File: rtl/vlx_byte_writer.sv
// VLX byte writer: JPEG 0xFF byte stuffing, small FIFO, single-byte Wishbone writes.
// Optional macro VLX_BYTE_STUFF_EN enables 0xFF -> 0xFF,0x00 stuffing (default: pass-through).
module vlx_byte_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_i,
  output logic             byte_rdy_o,
  input  logic             base_we_i,
  input  logic [31:0]      base_addr_i,
  output logic [31:0]      addr_o,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CntOne = (AW + 1)'(1);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty, fifo_full;
  logic             rdy_en_q;
  logic             accept, push, pop, term, in_write;
  logic             stuff_pending, stuff_push;
  logic [7:0]       push_data, head;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // Holds byte_rdy_o low while in reset; rises on the first edge after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  assign byte_rdy_o = rdy_en_q & ~stuff_pending & ~fifo_full;
  assign accept     = byte_vld_i & byte_rdy_o;

`ifdef VLX_BYTE_STUFF_EN
  logic stuff_q;

  // The 0x00 follow-up goes in on a later edge; input is held off until then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stuff_q <= 1'b0;
    end else if (stuff_push) begin
      stuff_q <= 1'b0;
    end else if (accept && (byte_i == 8'hFF)) begin
      stuff_q <= 1'b1;
    end
  end

  assign stuff_pending = stuff_q;
  assign stuff_push    = stuff_q & ~fifo_full;
`else
  assign stuff_pending = 1'b0;
  assign stuff_push    = 1'b0;
`endif

  assign push      = accept | stuff_push;
  assign push_data = stuff_push ? 8'h00 : byte_i;

  assign in_write = (state_q == StWrite);
  assign term     = in_write & (wb_ack_i | wb_err_i);
  assign pop      = term;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + CntOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StWrite;
      end
      StWrite: begin
        // Keep stb up back-to-back if another byte remains after this pop.
        if (term && (fifo_cnt <= CntOne) && !push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    wb_cyc_o = in_write;
    wb_stb_o = in_write;
    wb_we_o  = in_write;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    if (in_write) begin
      wb_adr_o = addr_q;
      wb_dat_o = {4{head}};
      unique case (addr_q[1:0])
        2'd0: wb_sel_o = 4'b1000;
        2'd1: wb_sel_o = 4'b0100;
        2'd2: wb_sel_o = 4'b0010;
        2'd3: wb_sel_o = 4'b0001;
        default: wb_sel_o = 4'b0000;
      endcase
    end
  end

  // An err (also with ack) discards the byte without advancing address or count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (term) begin
      if (wb_err_i) begin
        err_q <= 1'b1;
      end else begin
        addr_q <= addr_q + 32'd1;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end else if (base_we_i && !busy_o) begin
      addr_q <= base_addr_i;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end
  end

  assign addr_o     = addr_q;
  assign byte_cnt_o = cnt_q;
  assign err_o      = err_q;
  assign busy_o     = ~fifo_empty | stuff_pending | (state_q != StIdle);

endmodule

// File: tb/tb_vlx_byte_writer.sv
// Scoreboard bench for vlx_byte_writer: bytes queued on handshake, checked at each bus termination.
module tb_vlx_byte_writer;

`ifdef VLX_BYTE_STUFF_EN
  localparam bit Stuff = 1'b1;
`else
  localparam bit Stuff = 1'b0;
`endif
  localparam int unsigned Depth = 8;
  localparam int Budget = 2000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        byte_vld_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_rdy_o;
  logic        base_we_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] addr_o;
  logic [15:0] byte_cnt_o;
  logic        busy_o, err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  vlx_byte_writer #(.FIFO_DEPTH(Depth), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .byte_vld_i(byte_vld_i), .byte_i(byte_i), .byte_rdy_o(byte_rdy_o),
    .base_we_i(base_we_i), .base_addr_i(base_addr_i),
    .addr_o(addr_o), .byte_cnt_o(byte_cnt_o), .busy_o(busy_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard and reference model of the memory-side state.
  logic [7:0]  exp_q[$];
  logic [31:0] model_addr = '0;
  logic [15:0] model_cnt = '0;
  logic        model_err = 1'b0;
  int          ack_every = 1;
  int          err_at = -1;
  int          wr_idx = 0;
  int          wait_cnt = 0;

  function automatic logic [3:0] sel_for(input logic [1:0] a);
    case (a)
      2'd0: return 4'b1000;
      2'd1: return 4'b0100;
      2'd2: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Slave: terminate every ack_every-th strobed cycle; check the write being terminated.
  always @(negedge clk_i or negedge rst_ni) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (!rst_ni) begin
      wait_cnt = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wait_cnt >= ack_every - 1) begin
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
          wb_ack_i = 1'b1;
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("wb_we", {31'd0, wb_we_o}, 32'd1);
          check("wb_adr", wb_adr_o, model_addr);
          check("wb_dat", wb_dat_o, {4{e}});
          check("wb_sel", {28'd0, wb_sel_o}, {28'd0, sel_for(model_addr[1:0])});
          if (wr_idx == err_at) begin
            wb_err_i  = 1'b1;
            model_err = 1'b1;
          end else begin
            wb_ack_i   = 1'b1;
            model_addr = model_addr + 32'd1;
            model_cnt  = model_cnt + 16'd1;
          end
          wr_idx++;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Occupancy tracker for non-stuffed streams.
  int occ = 0;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) occ <= 0;
    else occ <= occ + int'(byte_vld_i & byte_rdy_o) - int'(wb_cyc_o & (wb_ack_i | wb_err_i));
  end

  bit track_full = 1'b0;
  bit saw_block = 1'b0;
  bit occ_bad = 1'b0;
  int occ_base = 0;

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk_i);
    byte_vld_i = 1'b1;
    byte_i = b;
    n = 0;
    while (!byte_rdy_o && n < Budget) begin
      if (track_full) begin
        saw_block = 1'b1;
        if (occ - occ_base != Depth) occ_bad = 1'b1;
      end
      @(negedge clk_i);
      n++;
    end
    if (n >= Budget) check("rdy_timeout", 32'd0, 32'd1);
    exp_q.push_back(b);
    if (Stuff && b == 8'hFF) exp_q.push_back(8'h00);
    @(posedge clk_i);
    #1 byte_vld_i = 1'b0;
  endtask

  task automatic load_base(input logic [31:0] a);
    @(negedge clk_i);
    base_we_i = 1'b1;
    base_addr_i = a;
    @(posedge clk_i);
    #1 base_we_i = 1'b0;
    model_addr = a;
    model_cnt = '0;
    model_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < Budget) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= Budget) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    check({tag, "_addr"}, addr_o, model_addr);
    check({tag, "_cnt"}, {16'd0, byte_cnt_o}, {16'd0, model_cnt});
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, model_err});
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_rdy", {31'd0, byte_rdy_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_cnt", {16'd0, byte_cnt_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_cyc", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rdy_after_rst", {31'd0, byte_rdy_o}, 32'd1);

    // Basic two-byte write; base_we while busy must be ignored.
    load_base(32'h0000_1000);
    send(8'h12);
    send(8'h34);
    @(negedge clk_i);
    base_we_i = 1'b1;
    base_addr_i = 32'hDEAD_0000;
    #1 check("base_we_busy_seen", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i);
    #1 base_we_i = 1'b0;
    wait_idle("basic");
    check("basic_final_addr", addr_o, 32'h0000_1002);

    // 0xFF stuffing.
    load_base(32'h0000_2000);
    send(8'hFF);
    @(negedge clk_i);
    check("stuff_rdy_low", {31'd0, byte_rdy_o}, Stuff ? 32'd0 : 32'd1);
    @(negedge clk_i);
    check("stuff_rdy_back", {31'd0, byte_rdy_o}, 32'd1);
    send(8'hA5);
    wait_idle("stuff");
    check("stuff_cnt", {16'd0, byte_cnt_o}, Stuff ? 32'd3 : 32'd2);

    // Slow slave vs continuous stream: backpressure at full FIFO.
    load_base(32'h0000_3000);
    ack_every = 5;
    occ_base = occ;
    track_full = 1'b1;
    for (int i = 1; i <= 12; i++) send(8'(i));
    track_full = 1'b0;
    wait_idle("stream");
    check("stream_blocked", {31'd0, saw_block}, 32'd1);
    check("stream_block_at_full", {31'd0, occ_bad}, 32'd0);
    check("stream_cnt", {16'd0, byte_cnt_o}, 32'd12);
    ack_every = 1;

    // Unaligned base.
    load_base(32'h0000_0003);
    send(8'h11);
    send(8'h22);
    wait_idle("unaligned");

    // Bus error on the middle write of three.
    load_base(32'h0000_4000);
    err_at = wr_idx + 1;
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    wait_idle("buserr");
    check("buserr_flag", {31'd0, err_o}, 32'd1);
    check("buserr_addr", addr_o, 32'h0000_4002);
    err_at = -1;
    load_base(32'h0000_5000);
    @(negedge clk_i);
    check("err_cleared", {31'd0, err_o}, 32'd0);

    // Asynchronous reset during a write with bytes queued.
    ack_every = 50;
    for (int i = 0; i < 4; i++) send(8'h41 + 8'(i));
    @(negedge clk_i);
    check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    exp_q.delete();
    model_addr = '0;
    model_cnt = '0;
    model_err = 1'b0;
    ack_every = 1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check("post_rst_addr", addr_o, 32'd0);
    check("post_rst_cnt", {16'd0, byte_cnt_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    check("post_rst_no_cyc", {31'd0, wb_cyc_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vlx_byte_writer.md
Name: vlx_byte_writer

Overview:
- Downstream stage of the VLX bit packer in the OR1200 JPEG path.
- Accepts packed entropy-coded bytes over a valid/ready handshake and applies JPEG 0xFF->0xFF,0x00 byte stuffing.
- Buffers the result in a small FIFO and writes each byte to memory as a single-byte Wishbone write, starting at a programmable base address.
- Lets the packer hand off bytes in one cycle instead of stalling the CPU for each bus ack.

Parameters:
- FIFO_DEPTH, 8, FIFO entries (power of two, >= 4).
- CNT_W, 16, width of the bytes-written counter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous reset, active low
- byte_vld_i  in  1  packer offers byte_i
- byte_i  in  8  packed byte
- byte_rdy_o  out  1  byte accepted this cycle when vld & rdy
- base_we_i  in  1  load base_addr_i into the write pointer
- base_addr_i  in  32  start address
- addr_o  out  32  next memory address to be written
- byte_cnt_o  out  CNT_W  bytes written to memory since last base load (includes stuffed 0x00)
- busy_o  out  1  FIFO non-empty, stuff pending, or bus cycle active
- err_o  out  1  sticky bus error
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte lane select
- wb_ack_i, wb_err_i  in  1  Wishbone termination

Behaviour:
- Reset (rst_ni=0, async):
  - Outputs: byte_rdy_o=0; addr_o=0; byte_cnt_o=0; busy_o=0; err_o=0; all wb_* outputs=0.
  - Internal: FIFO empty; stuff_pending=0; FSM=IDLE.
  - byte_rdy_o may rise in the first cycle after deassertion.
- Input side:
  - byte_rdy_o = !stuff_pending & !fifo_full.
  - An accepted byte is pushed in the same edge.
  - If the accepted byte is 0xFF, set stuff_pending. The next cycle pushes 0x00 as soon as the FIFO is not full, then clears stuff_pending.
  - byte_rdy_o stays low while stuff_pending=1.
- FIFO:
  - Pointers carry a wrap bit; full when the pointers match and the wrap bits differ.
  - A simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - No overflow is possible because of the rdy gating.
- Bus FSM:
  - IDLE: when the FIFO is non-empty, go to WRITE and assert cyc/stb/we on the next edge.
  - WRITE: wb_adr_o=addr_o. wb_dat_o replicates the head byte on all four lanes.
  - wb_sel_o is big-endian from addr[1:0]: 0->1000, 1->0100, 2->0010, 3->0001.
  - Outputs are held stable until ack or err.
  - On wb_ack_i: pop; addr_o+=1; byte_cnt_o+=1 (wraps modulo 2^CNT_W). If the FIFO still has another entry, stay in WRITE with the next byte on the following cycle (stb stays high). Otherwise go to IDLE and drop cyc/stb.
  - On wb_err_i: pop and discard the byte; set err_o; addr_o and byte_cnt_o do not change; then follow the same continue/IDLE rule as ack.
  - Ack and err together count as err.
- Address:
  - addr_o wraps from 0xFFFFFFFF to 0.
  - base_we_i is honoured only when busy_o=0 and it loads addr_o, clears byte_cnt_o and clears err_o.
  - base_we_i while busy_o=1 is ignored.
- busy_o = fifo non-empty | stuff_pending | FSM!=IDLE. It is registered on the same edges as the state it reflects.
- Reset mid-transaction aborts the bus cycle immediately (cyc/stb low) and the buffered data is lost.

Optional Feature:
- VLX_BYTE_STUFF_EN
  - Defined: 0xFF stuffing active as described above.
  - Undefined: bytes pass unmodified; stuff_pending is absent and byte_rdy_o = !fifo_full.

Test Plan:
- base_we_i with 0x0000_1000, then bytes 0x12,0x34 -> two writes at 0x1000 (sel 1000, dat 0x12121212) and 0x1001 (sel 0100); addr_o=0x1002; byte_cnt_o=2; busy_o falls after the second ack.
- Bytes 0xFF,0xA5 with stuffing enabled -> writes 0xFF, 0x00, 0xA5 at consecutive addresses; byte_rdy_o low for exactly one cycle after the 0xFF handshake; byte_cnt_o=3. With the macro undefined -> only two writes.
- Slave acks only every 5th cycle while the packer streams 0x01..0x0C continuously -> byte_rdy_o drops when 8 entries are held, no byte is lost or reordered, all 12 writes complete in order.
- Base 0x0000_0003, bytes 0x11,0x22 -> sel 0001 at 0x3, then sel 1000 at 0x4.
- wb_err_i on the second of three writes -> err_o=1; the third byte is written at base+1; byte_cnt_o=2. A subsequent base_we_i while idle clears err_o.
- rst_ni pulsed low during WRITE with 4 bytes queued -> cyc/stb drop asynchronously; after release FIFO is empty, busy_o=0, addr_o=0.
